mac_job_scheduler: RTL and testbench
====================================

# mac_job_scheduler

Job-level controller for the pipelined matrix MAC unit. Arbitrates round-robin between `NUM_REQ` requesters that each want one full M×K by K×N multiply. For the granted requester it clears the MAC, holds `mac_start` until the MAC reports `mac_done`, and returns a completion pulse. A watchdog aborts jobs that never finish. It sits between the host/requester logic and the MAC unit; the memory-port mux is steered by `gnt_id`.

## Interface
- `NUM_REQ`, 2: number of requesters, ≥2.
- `CLR_CYCLES`, 2: cycles `mac_rstn` is held low before each job, ≥1.
- `TIMEOUT_CYCLES`, 256: maximum RUN cycles before abort, ≥1.
- `CNT_WIDTH`, 16: width of the completed-job counter.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester job request; level, held until that requester's `done` pulse.
- `gnt`  out  NUM_REQ  one-hot grant, high from CLEAR through DONE/ABORT.
- `gnt_id`  out  $clog2(NUM_REQ)  index of the current/last grantee; memory mux select.
- `done`  out  NUM_REQ  one-cycle completion pulse to the grantee.
- `err`  out  NUM_REQ  one-cycle pulse coincident with `done` when the job timed out.
- `busy`  out  1  high in every state except IDLE.
- `mac_rstn`  out  1  active-low clear to the MAC unit.
- `mac_start`  out  1  MAC run enable.
- `mac_done`  in  1  MAC completion pulse.
- `jobs_done`  out  CNT_WIDTH  count of successful jobs; saturates at all-ones.

## Operation
- All outputs are registered.
- Reset values: `gnt`=0, `gnt_id`=0, `done`=0, `err`=0, `busy`=0, `mac_rstn`=0, `mac_start`=0, `jobs_done`=0. The round-robin pointer resets to 0, and the FSM resets to IDLE.
- FSM states: IDLE, CLEAR, RUN, DONE, ABORT.
- **IDLE:**
  - `mac_rstn`=1.
  - If any `req` bit is set, pick the first set bit searching upward from the pointer, with wrap.
  - Register `gnt`/`gnt_id` and go to CLEAR.
  - With no request, stay in IDLE.
- **CLEAR:**
  - `mac_rstn`=0 for exactly `CLR_CYCLES` cycles, then go to RUN.
  - The watchdog counter is cleared here.
- **RUN:**
  - `mac_start`=1 and `mac_rstn`=1; the watchdog increments each cycle.
  - If `mac_done` is sampled high, go to DONE.
  - Otherwise, when the watchdog reaches `TIMEOUT_CYCLES`, go to ABORT.
  - If `mac_done` arrives on the same cycle as the timeout, `mac_done` wins (DONE, no error).
- **DONE:**
  - `mac_start`=0 and `done[gnt_id]`=1 for one cycle.
  - `jobs_done` increments, saturating at all-ones.
  - The pointer moves to `gnt_id+1`, wrapping modulo `NUM_REQ`.
  - Go to IDLE. `gnt` clears on entry to IDLE.
- **ABORT:**
  - Same as DONE, but `err[gnt_id]`=1 and `jobs_done` does not increment.
  - The pointer still advances.
- `mac_done` outside RUN is ignored.
- Deasserting `req` mid-job does not cancel the job; it runs to DONE/ABORT and still pulses `done`.
- `req` for the grantee still high in the IDLE cycle after DONE is treated as a new job, at lowest priority behind the other requesters.
- `gnt_id` holds its last value while in IDLE.
- `rst` in any state returns to reset values on the next edge. `mac_rstn` drops to 0 immediately on that edge, so the MAC is cleared.

## Timing
- Request → grant: `req` sampled high in IDLE at edge t → `gnt`, `busy` high and `mac_rstn` low from t+1.
- `mac_start` rises at t+1+`CLR_CYCLES`.
- `mac_done` sampled at edge u → `mac_start` low and `done` high at u+1 → IDLE at u+2.
- Earliest next grant is visible at u+3, so back-to-back jobs have 2 idle-side cycles between `mac_start` periods plus `CLR_CYCLES`.
- Timeout: with no `mac_done`, `mac_start` is high for exactly `TIMEOUT_CYCLES` cycles. ABORT follows, with `err`/`done` high for one cycle.
- `done`/`err` never exceed one cycle and never assert for a non-granted index.

## Test plan
- Single job: `req`=01, MAC returns `mac_done` 20 cycles after `mac_start` rises.
  - Expect `gnt`=01 and `mac_rstn` low 2 cycles, then `mac_start` high 20 cycles.
  - Expect `done`=01 for one cycle and `jobs_done`=1.
- Contention: `req`=11 held continuously, each job completing normally.
  - Expect `gnt` sequence 01, 10, 01, 10 and `done` alternating, with `jobs_done`=4 after four jobs.
- Timeout: `req`=10, `mac_done` never asserted, `TIMEOUT_CYCLES`=256.
  - Expect 256 cycles of `mac_start`, then `err`=10 and `done`=10 together for one cycle.
  - Expect `jobs_done` unchanged and FSM back in IDLE.
- Race: `mac_done` asserted on the exact cycle the watchdog hits 256 → DONE path, `err`=0, `jobs_done` increments.
- Mid-job reset: assert `rst` for 1 cycle during RUN.
  - Expect all outputs at reset values the next cycle, with `mac_rstn`=0.
  - With `req`=01 held, a fresh CLEAR starts right after `rst` drops.
- Stray/withdrawn: `mac_done` pulsed in IDLE → no state change. `req` dropped during RUN → job still ends with `done` pulse.

Source files
------------

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: round-robin job controller for the pipelined matrix MAC.
// Grants one requester at a time, clears the MAC, runs it until mac_done or a
// watchdog timeout, then pulses done (and err on timeout) to the grantee.
// Every output is registered from the next-state value, so each output changes
// on the same edge as the state it belongs to.
module mac_job_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_id,
  output logic [NUM_REQ-1:0]         o_done,
  output logic [NUM_REQ-1:0]         o_err,
  output logic                       o_busy,
  output logic                       o_mac_rstn,
  output logic                       o_mac_start,
  input  logic                       i_mac_done,
  output logic [CNT_WIDTH-1:0]       o_jobs_done
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CCW = $clog2(CLR_CYCLES + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [CCW-1:0]   r_clr_cnt;
  logic [WDW-1:0]   r_wd;

  logic             w_any;
  logic [IDW-1:0]   w_pick;
  logic             w_clr_last;
  logic             w_wd_hit;
  logic [IDW-1:0]   w_ptr_inc;

  logic [NUM_REQ-1:0]   w_gnt_n;
  logic [IDW-1:0]       w_gnt_id_n;
  logic [NUM_REQ-1:0]   w_done_n;
  logic [NUM_REQ-1:0]   w_err_n;
  logic                 w_busy_n;
  logic                 w_rstn_n;
  logic                 w_start_n;
  logic [CNT_WIDTH-1:0] w_jobs_n;

  // First set request at or above the pointer, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDW-1:0] ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign w_any      = |i_req;
  assign w_pick     = rr_pick(i_req, r_ptr);
  assign w_clr_last = (r_clr_cnt == CCW'(CLR_CYCLES - 1));
  assign w_wd_hit   = (r_wd == WDW'(TIMEOUT_CYCLES - 1));
  assign w_ptr_inc  = (o_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : o_gnt_id + IDW'(1);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; in RUN a mac_done beats a simultaneous timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_CLEAR : S_IDLE;
      S_CLEAR: w_next = w_clr_last ? S_RUN : S_CLEAR;
      S_RUN: begin
        if (i_mac_done) begin
          w_next = S_DONE;
        end else if (w_wd_hit) begin
          w_next = S_ABORT;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    w_gnt_n    = o_gnt;
    w_gnt_id_n = o_gnt_id;
    w_done_n   = '0;
    w_err_n    = '0;
    w_busy_n   = (w_next != S_IDLE);
    w_rstn_n   = (w_next != S_CLEAR);
    w_start_n  = (w_next == S_RUN);
    w_jobs_n   = o_jobs_done;
    if (r_state == S_IDLE && w_any) begin
      w_gnt_n    = onehot(w_pick);
      w_gnt_id_n = w_pick;
    end else if (w_next == S_IDLE) begin
      w_gnt_n = '0;
    end else begin
      w_gnt_n = o_gnt;
    end
    if (w_next == S_DONE) begin
      w_done_n = onehot(o_gnt_id);
      if (o_jobs_done != {CNT_WIDTH{1'b1}}) begin
        w_jobs_n = o_jobs_done + CNT_WIDTH'(1);
      end else begin
        w_jobs_n = o_jobs_done;
      end
    end else if (w_next == S_ABORT) begin
      w_done_n = onehot(o_gnt_id);
      w_err_n  = onehot(o_gnt_id);
    end else begin
      w_done_n = '0;
    end
  end

  // Output registers; reset forces mac_rstn low so the MAC is cleared at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt       <= '0;
      o_gnt_id    <= '0;
      o_done      <= '0;
      o_err       <= '0;
      o_busy      <= 1'b0;
      o_mac_rstn  <= 1'b0;
      o_mac_start <= 1'b0;
      o_jobs_done <= '0;
    end else begin
      o_gnt       <= w_gnt_n;
      o_gnt_id    <= w_gnt_id_n;
      o_done      <= w_done_n;
      o_err       <= w_err_n;
      o_busy      <= w_busy_n;
      o_mac_rstn  <= w_rstn_n;
      o_mac_start <= w_start_n;
      o_jobs_done <= w_jobs_n;
    end
  end

  // Clear-phase length counter, watchdog and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clr_cnt <= '0;
      r_wd      <= '0;
      r_ptr     <= '0;
    end else begin
      r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + CCW'(1) : '0;
      r_wd      <= (r_state == S_RUN) ? r_wd + WDW'(1) : '0;
      if (r_state == S_DONE || r_state == S_ABORT) begin
        r_ptr <= w_ptr_inc;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler: a table of whole-job records plus
// hand-written reset, stray-done and mid-job-reset sequences.
module tb_mac_job_scheduler;

  localparam int CLR = 2;
  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [0:0]  gnt_id;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        busy;
  logic        mac_rstn;
  logic        mac_start;
  logic        mac_done;
  logic [15:0] jobs_done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  rq;     // request pattern driven for the job
    int          lat;    // mac_start cycles before mac_done (0 = never)
    logic        tmo;    // job is expected to time out
    logic [1:0]  eg;     // expected one-hot grant
    logic [15:0] ej;     // expected jobs_done after the job
    logic        drop;   // withdraw req once RUN starts
    logic [1:0]  ra;     // request pattern after the done pulse
  } job_t;

  job_t tbl [8];

  mac_job_scheduler #(
    .NUM_REQ(2), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt), .o_gnt_id(gnt_id),
    .o_done(done), .o_err(err), .o_busy(busy), .o_mac_rstn(mac_rstn),
    .o_mac_start(mac_start), .i_mac_done(mac_done), .o_jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input job_t j);
    int cnt;
    int bound;
    req = j.rq;
    bound = 0;
    while (gnt == 2'b00 && bound < 10) begin
      step();
      bound++;
    end
    chk("grant", 32'(gnt), 32'(j.eg));
    chk("gnt_id", 32'(gnt_id), 32'(j.eg[1]));
    chk("busy_clear", 32'(busy), 32'd1);
    chk("rstn_clear", 32'(mac_rstn), 32'd0);
    cnt = 1;
    bound = 0;
    while (mac_rstn == 1'b0 && bound < 20) begin
      step();
      if (mac_rstn == 1'b0) cnt++;
      bound++;
    end
    chk("clear_len", 32'(cnt), 32'(CLR));
    chk("start_rise", 32'(mac_start), 32'd1);
    if (j.drop) req = 2'b00;
    cnt = 1;
    bound = 0;
    while (mac_start == 1'b1 && bound < 400) begin
      if (j.lat != 0 && cnt == j.lat) mac_done = 1'b1;
      step();
      mac_done = 1'b0;
      if (mac_start == 1'b1) cnt++;
      bound++;
    end
    chk("run_len", 32'(cnt), j.tmo ? 32'(TMO) : 32'(j.lat));
    chk("done_pulse", 32'(done), 32'(j.eg));
    chk("err_pulse", 32'(err), j.tmo ? 32'(j.eg) : 32'd0);
    chk("jobs_done", 32'(jobs_done), 32'(j.ej));
    chk("gnt_in_done", 32'(gnt), 32'(j.eg));
    req = j.ra;
    step();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_gnt_id", 32'(gnt_id), 32'(j.eg[1]));
  endtask

  initial begin
    //        rq     lat  tmo   eg     ej  drop  ra
    tbl[0] = '{2'b01, 20, 1'b0, 2'b01, 16'd1, 1'b0, 2'b00}; // single job
    tbl[1] = '{2'b11,  5, 1'b0, 2'b10, 16'd2, 1'b0, 2'b11}; // contention
    tbl[2] = '{2'b11,  6, 1'b0, 2'b01, 16'd3, 1'b0, 2'b11};
    tbl[3] = '{2'b11,  4, 1'b0, 2'b10, 16'd4, 1'b0, 2'b11};
    tbl[4] = '{2'b11,  3, 1'b0, 2'b01, 16'd5, 1'b0, 2'b00};
    tbl[5] = '{2'b10,  0, 1'b1, 2'b10, 16'd5, 1'b0, 2'b00}; // timeout
    tbl[6] = '{2'b01,  7, 1'b0, 2'b01, 16'd6, 1'b1, 2'b00}; // req withdrawn
    tbl[7] = '{2'b01, TMO, 1'b0, 2'b01, 16'd7, 1'b0, 2'b00}; // done/timeout race

    rst = 1'b1;
    req = 2'b00;
    mac_done = 1'b0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rstn", 32'(mac_rstn), 32'd0);
    chk("rst_start", 32'(mac_start), 32'd0);
    chk("rst_jobs", 32'(jobs_done), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_rstn", 32'(mac_rstn), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i]);
    end

    // Stray mac_done in IDLE must not start anything.
    mac_done = 1'b1;
    step();
    mac_done = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_start", 32'(mac_start), 32'd0);
    chk("stray_done", 32'(done), 32'd0);
    step();
    chk("stray_busy2", 32'(busy), 32'd0);
    chk("stray_jobs", 32'(jobs_done), 32'd7);

    // Reset during RUN, then a fresh job with req held.
    req = 2'b01;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_start", 32'(mac_start), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rstn", 32'(mac_rstn), 32'd0);
    chk("mid_rst_start", 32'(mac_start), 32'd0);
    chk("mid_rst_jobs", 32'(jobs_done), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'd1);
    chk("post_rst_rstn", 32'(mac_rstn), 32'd0);
    run_job('{2'b01, 3, 1'b0, 2'b01, 16'd1, 1'b0, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
